// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types and constants for the instruction-memory responder
package imem_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;
    localparam logic [INSTR_W-1:0] DEF_ERR_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } imem_state_t;

    // A fetch faults when it is not word aligned or falls past the last stored word.
    function automatic logic addr_fault(input logic [ADDR_W-1:0] addr, input int depth);
        return (addr[1:0] != 2'b00) || (addr >= ADDR_W'(4 * depth));
    endfunction

endpackage

// File: rtl/imem_array.sv
// rtl/imem_array.sv - word storage with a synchronous load port and combinational read
module imem_array
    import imem_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     ld_en,
    input  logic [$clog2(DEPTH)-1:0] ld_addr,
    input  logic [INSTR_W-1:0]       ld_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [INSTR_W-1:0]       rd_data
);

    logic [INSTR_W-1:0] mem [DEPTH];

    // Program contents survive reset; only the load port changes them.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - fetch-request responder with wait states, flush and error reporting
module imem_responder
    import imem_pkg::*;
#(
    parameter int                 DEPTH    = 64,
    parameter int                 WAIT_CYC = 1,
    parameter logic [INSTR_W-1:0] ERR_WORD = DEF_ERR_WORD
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ADDR_W-1:0]        req_addr,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [INSTR_W-1:0]       rsp_data,
    output logic                     rsp_err,
    input  logic                     flush,
    input  logic                     ld_en,
    input  logic [$clog2(DEPTH)-1:0] ld_addr,
    input  logic [INSTR_W-1:0]       ld_data
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

    imem_state_t        state;
    imem_state_t        state_next;
    logic [3:0]         cnt;
    logic [3:0]         cnt_next;
    logic [AW-1:0]      addr_q;
    logic               err_q;
    logic               capture;
    logic               load_rsp;
    logic               req_err;
    logic [AW-1:0]      rd_idx;
    logic               rd_err;
    logic [INSTR_W-1:0] rd_data;

    assign req_err = addr_fault(req_addr, DEPTH);

    // With zero wait states RESP is entered on the accept edge, so the live request feeds the read.
    assign rd_idx = (state == IDLE) ? req_addr[2 +: AW] : addr_q;
    assign rd_err = (state == IDLE) ? req_err : err_q;

    imem_array #(
        .DEPTH(DEPTH)
    ) u_array (
        .clk     (clk),
        .ld_en   (ld_en),
        .ld_addr (ld_addr),
        .ld_data (ld_data),
        .rd_addr (rd_idx),
        .rd_data (rd_data)
    );

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        capture    = 1'b0;
        load_rsp   = 1'b0;
        if (flush) begin
            state_next = IDLE;
            cnt_next   = 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        capture = 1'b1;
                        if (WAIT_CYC > 0) begin
                            state_next = WAIT;
                            cnt_next   = WAIT_LOAD;
                        end else begin
                            state_next = RESP;
                            load_rsp   = 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state_next = RESP;
                        load_rsp   = 1'b1;
                    end else begin
                        cnt_next = cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            addr_q   <= '0;
            err_q    <= 1'b0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (capture) begin
                addr_q <= req_addr[2 +: AW];
                err_q  <= req_err;
            end
            // Faulting fetches never take the array word.
            if (load_rsp) begin
                rsp_data <= rd_err ? ERR_WORD : rd_data;
                rsp_err  <= rd_err;
            end
        end
    end

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder: the far end of the fetch unit's instruction request path.
- Accepts a byte-addressed fetch request carrying the PC and returns the 32-bit instruction word after a configurable number of wait states, using a valid/ready handshake on both request and response.
- A flush input drops an in-flight request when the fetch unit redirects (pc_update).
- A load port preloads program words before or between runs.

Parameters:
- DEPTH, 64, number of 32-bit words stored; power of two.
- WAIT_CYC, 1, wait-state cycles between request accept and response valid; 0 to 15.
- ERR_WORD, 32'h0000_0000, instruction value returned on an error response.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  fetch unit presents a request.
- req_ready  output  1  responder can accept a request.
- req_addr  input  32  byte address (PC) of the requested instruction.
- rsp_valid  output  1  response word valid.
- rsp_ready  input  1  fetch unit accepts the response.
- rsp_data  output  32  instruction word.
- rsp_err  output  1  request was misaligned or out of range.
- flush  input  1  discard any pending request or response.
- ld_en  input  1  write one word into the array.
- ld_addr  input  $clog2(DEPTH)  word index for the load.
- ld_data  input  32  word to store.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE; wait counter clears.
  - req_ready=1 once reset is released; rsp_valid=0, rsp_data=0, rsp_err=0.
  - Array contents are not reset.
- Address decode:
  - Word index = req_addr[2 +: $clog2(DEPTH)].
  - Error when req_addr[1:0]!=0 or req_addr >= 4*DEPTH.
  - On error, rsp_data=ERR_WORD and rsp_err=1. No array access occurs.
- IDLE:
  - req_ready=1.
  - req_valid=1 at a rising edge accepts the request: address and error flag are captured.
  - Next state is WAIT if WAIT_CYC>0, otherwise RESP.
- WAIT:
  - req_ready=0.
  - Counter loads WAIT_CYC-1 on entry and decrements each cycle; moves to RESP on the cycle the counter is 0.
  - Total latency from accept edge to rsp_valid=1 is WAIT_CYC+1 cycles.
- RESP:
  - rsp_data and rsp_err are registered on entry.
  - rsp_valid=1, with data held stable until rsp_ready=1 at a rising edge; then the FSM returns to IDLE.
  - No back-to-back accept in the same cycle; the next request is accepted in IDLE.
- Array read timing:
  - The array is read on the cycle of the transition into RESP.
  - A load to the same word on that same edge is not visible; the old word is returned.
  - A load on any earlier cycle is visible.
- flush:
  - From any state, flush=1 at an edge forces IDLE, rsp_valid=0, and clears the counter.
  - flush has priority over rsp_ready and over a concurrent req_valid; no request is accepted in a flush cycle.
- Load port:
  - ld_en=1 writes ld_data to ld_addr at the rising edge, in any state.
  - Loads are independent of the handshake.
- Reset mid-operation: the pending request is lost and the FSM is in IDLE after reset release.
- Width rules:
  - Upper address bits beyond the array range only feed the range-error check.
  - ld_addr is exactly $clog2(DEPTH) bits; there is no wrap-around of request addresses.

Decomposition:
- Shared package imem_pkg:
  - state enum imem_state_t {IDLE, WAIT, RESP};
  - constant INSTR_W=32;
  - default ERR_WORD.
- One sub-module, imem_array: DEPTH x 32 synchronous-write, combinational-read storage with a load port.
- The FSM, counter and response registers stay in imem_responder.

Test Plan:
- Preload: words 0..4 = 1,2,3,4,5 via the load port; WAIT_CYC=1. Request addr 0,4,8,12,16 with rsp_ready=1 → rsp_data 1,2,3,4,5, each rsp_valid exactly 2 cycles after its accept edge, rsp_err=0.
- WAIT_CYC=0, request addr 8 → rsp_valid one cycle after accept, data 3. WAIT_CYC=3 → rsp_valid 4 cycles after accept.
- Backpressure: hold rsp_ready=0 for 5 cycles on addr 4 → rsp_valid=1 and rsp_data=2 stable, req_ready=0 throughout. Raise rsp_ready → FSM returns to IDLE next cycle.
- Errors:
  - Request addr 6 (misaligned) → rsp_err=1, rsp_data=ERR_WORD.
  - Request addr 256 with DEPTH=64 (out of range) → rsp_err=1, rsp_data=ERR_WORD.
- flush:
  - flush asserted during WAIT for addr 12 → no rsp_valid.
  - Then request addr 128 (pc_update target, in range for DEPTH=64? no, 128 < 256) → data from word 32.
  - flush and req_valid in the same cycle → request not accepted.
- Reset and load collision:
  - Drive reset=0 during RESP → rsp_valid drops immediately (asynchronous), req_ready=1 after release.
  - Load word 1 = 9 on the RESP-entry edge of a request to addr 4 → returns 2. A repeat request returns 9.
